// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing NUM_CHANNELS memory channels among
// NUM_CONSUMERS requesters with valid/ready read and write handshakes.
// Each channel runs a claim FSM: IDLE -> *_WAIT -> *_RELAY -> IDLE.
// Optional build macro MEM_ARBITER_PERF_EN adds per-channel busy counters and
// a total grant counter (perf_busy_cycles, perf_grants).
module mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]            mem_read_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]            mem_write_valid,
  output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]            mem_write_ready
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [NUM_CHANNELS*16-1:0]         perf_busy_cycles,
  output logic [15:0]                        perf_grants
`endif
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_WAIT,
    ST_WRITE_WAIT,
    ST_READ_RELAY,
    ST_WRITE_RELAY
  } state_t;

  state_t                   r_state [NUM_CHANNELS];
  logic [CW-1:0]            r_owner [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] r_claimed;
  logic [CW-1:0]            r_rr_ptr;

  logic [NUM_CONSUMERS-1:0] w_write_req;
  logic [NUM_CONSUMERS-1:0] w_cand;
  logic [NUM_CHANNELS-1:0]  w_grant;
  logic [NUM_CHANNELS-1:0]  w_grant_read;
  logic [CW-1:0]            w_grant_idx [NUM_CHANNELS];
  logic [CW-1:0]            w_rr_next;
  logic [NUM_CONSUMERS-1:0] w_taken;
  logic                     w_found;
  int                       w_idx;
  logic [CW-1:0]            w_sel;

  // With the write path removed, write requests never make a consumer a candidate.
  assign w_write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
  assign w_cand      = ~r_claimed & (consumer_read_valid | w_write_req);

  // Grant resolution: IDLE channels in ascending order each take the next
  // unclaimed candidate, searching from rr_ptr with wrap-around.
  always_comb begin
    // NOTE: every variable gets a default before any conditional logic so no latch is inferred.
    w_grant      = '0;
    w_grant_read = '0;
    w_rr_next    = r_rr_ptr;
    w_taken      = '0;
    w_found      = 1'b0;
    w_idx        = 0;
    w_sel        = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_grant_idx[c] = '0;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (r_state[c] == ST_IDLE) begin
        w_found = 1'b0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
          w_idx = int'(r_rr_ptr) + k;
          if (w_idx >= NUM_CONSUMERS) w_idx = w_idx - NUM_CONSUMERS;
          w_sel = CW'(w_idx);
          if (!w_found && w_cand[w_sel] && !w_taken[w_sel]) begin
            w_found         = 1'b1;
            w_taken[w_sel]  = 1'b1;
            w_grant[c]      = 1'b1;
            w_grant_idx[c]  = w_sel;
            // Read wins when a consumer raises both valids.
            w_grant_read[c] = consumer_read_valid[w_sel];
            w_rr_next       = (w_idx == NUM_CONSUMERS - 1) ? '0 : CW'(w_idx + 1);
          end
        end
      end
    end
  end

  // Channel claim FSMs, round-robin pointer and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the per-channel state/owner arrays are a handful of flops, not a RAM, so they are reset like any other register.
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_state[c] <= ST_IDLE;
        r_owner[c] <= '0;
      end
      r_claimed            <= '0;
      r_rr_ptr             <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every channel sees the same pre-edge values.
      if (|w_grant) r_rr_ptr <= w_rr_next;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (r_state[c])
          ST_IDLE: begin
            if (w_grant[c]) begin
              r_owner[c]                   <= w_grant_idx[c];
              r_claimed[w_grant_idx[c]]    <= 1'b1;
              if (w_grant_read[c]) begin
                mem_read_valid[c]                          <= 1'b1;
                mem_read_address[c*ADDR_BITS +: ADDR_BITS] <=
                  consumer_read_address[w_grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                r_state[c]                                 <= ST_READ_WAIT;
              end else begin
                mem_write_valid[c]                          <= 1'b1;
                mem_write_address[c*ADDR_BITS +: ADDR_BITS] <=
                  consumer_write_address[w_grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                mem_write_data[c*DATA_BITS +: DATA_BITS]    <=
                  consumer_write_data[w_grant_idx[c]*DATA_BITS +: DATA_BITS];
                r_state[c]                                  <= ST_WRITE_WAIT;
              end
            end
          end
          ST_READ_WAIT: begin
            if (mem_read_ready[c]) begin
              mem_read_valid[c]                                    <= 1'b0;
              consumer_read_data[r_owner[c]*DATA_BITS +: DATA_BITS] <=
                mem_read_data[c*DATA_BITS +: DATA_BITS];
              consumer_read_ready[r_owner[c]]                      <= 1'b1;
              r_state[c]                                           <= ST_READ_RELAY;
            end
          end
          ST_WRITE_WAIT: begin
            if (mem_write_ready[c]) begin
              mem_write_valid[c]               <= 1'b0;
              consumer_write_ready[r_owner[c]] <= 1'b1;
              r_state[c]                       <= ST_WRITE_RELAY;
            end
          end
          ST_READ_RELAY: begin
            // Hold ready until the consumer lets go of read_valid.
            if (!consumer_read_valid[r_owner[c]]) begin
              consumer_read_ready[r_owner[c]] <= 1'b0;
              r_claimed[r_owner[c]]           <= 1'b0;
              r_state[c]                      <= ST_IDLE;
            end
          end
          ST_WRITE_RELAY: begin
            if (!consumer_write_valid[r_owner[c]]) begin
              consumer_write_ready[r_owner[c]] <= 1'b0;
              r_claimed[r_owner[c]]            <= 1'b0;
              r_state[c]                       <= ST_IDLE;
            end
          end
          default: r_state[c] <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  localparam int GCW = $clog2(NUM_CHANNELS + 1);

  logic [GCW-1:0] w_grant_count;
  logic [16:0]    w_grant_sum;

  // Number of grants issued this cycle, and the unsaturated new total.
  always_comb begin
    w_grant_count = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_grant[c]) w_grant_count = w_grant_count + GCW'(1);
    end
    w_grant_sum = {1'b0, perf_grants} + 17'(w_grant_count);
  end

  // Saturating busy-cycle counters per channel and a saturating grant total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_busy_cycles <= '0;
      perf_grants      <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (r_state[c] != ST_IDLE && perf_busy_cycles[c*16 +: 16] != 16'hFFFF) begin
          perf_busy_cycles[c*16 +: 16] <= perf_busy_cycles[c*16 +: 16] + 16'd1;
        end
      end
      perf_grants <= w_grant_sum[16] ? 16'hFFFF : w_grant_sum[15:0];
    end
  end
`endif

endmodule
